// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_arbiter
//  Purpose  : Round-robin arbiter sharing system-RAM port B between host
//             128-bit writes, UART 32-bit lane writes and locked TX reads.
//             Registered RAM drive, read-valid return pipe, lock starvation
//             guard.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int RD_LAT   = 2,
   parameter int MAX_LOCK = 64
) (
   input  logic                I_clk,
   input  logic                I_Rst_n,
   input  logic                I_host_req,
   input  logic [ADDR_W-1:0]   I_host_addr,
   input  logic [127:0]        I_host_data,
   output logic                O_host_ack,
   input  logic                I_uart_req,
   input  logic [ADDR_W+1:0]   I_uart_addr,
   input  logic [31:0]         I_uart_data,
   output logic                O_uart_ack,
   input  logic                I_rd_req,
   input  logic                I_rd_lock,
   input  logic [ADDR_W-1:0]   I_rd_addr,
   output logic                O_rd_ack,
   output logic [127:0]        O_rd_data,
   output logic                O_rd_vld,
   output logic                O_ram_en,
   output logic [15:0]         O_ram_wen,
   output logic [ADDR_W-1:0]   O_ram_addr,
   output logic [127:0]        O_ram_wdata,
   input  logic [127:0]        I_ram_rdata,
   output logic [1:0]          O_owner,
   output logic                O_locked
);

   localparam logic [1:0] C_OWN_HOST = 2'd0;
   localparam logic [1:0] C_OWN_UART = 2'd1;
   localparam logic [1:0] C_OWN_RD   = 2'd2;
   localparam logic [1:0] C_OWN_NONE = 2'd3;

   localparam logic [0:0] ST_RR   = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   localparam int                 C_CNT_W     = $clog2(MAX_LOCK + 1);
   localparam logic [C_CNT_W-1:0] C_LOCK_LAST = C_CNT_W'(MAX_LOCK - 1);

   logic [0:0]          r_state;
   logic [0:0]          w_state_nxt;
   logic [C_CNT_W-1:0]  r_lock_cnt;
   logic [C_CNT_W-1:0]  w_lock_cnt_nxt;
   logic                r_excl_rd;
   logic                w_excl_rd_nxt;
   logic [1:0]          r_owner;
   logic [1:0]          w_rr_last;
   logic                w_rd_elig;
   logic [2:0]          w_gnt;        // {read, uart, host}
   logic [15:0]         w_uart_wen;
   logic                r_ram_en;
   logic [15:0]         r_ram_wen;
   logic [ADDR_W-1:0]   r_ram_addr;
   logic [127:0]        r_ram_wdata;
   logic [RD_LAT:0]     r_rd_pipe;

   // Before any grant the last winner is taken as read, giving host first pick
   assign w_rr_last  = (r_owner == C_OWN_NONE) ? C_OWN_RD : r_owner;
   assign w_uart_wen = 16'h000F << {I_uart_addr[1:0], 2'b00};

   // Grant selection: rotate priority after the last winner; lock owns the port
   always_comb begin
      w_rd_elig = I_rd_req && !(r_excl_rd && (I_host_req || I_uart_req));
      w_gnt     = 3'b000;
      if (r_state == ST_LOCK) begin
         w_gnt[2] = I_rd_req;
      end else begin
         case (w_rr_last)
            C_OWN_HOST: begin
               if (I_uart_req)      w_gnt[1] = 1'b1;
               else if (w_rd_elig)  w_gnt[2] = 1'b1;
               else if (I_host_req) w_gnt[0] = 1'b1;
            end
            C_OWN_UART: begin
               if (w_rd_elig)       w_gnt[2] = 1'b1;
               else if (I_host_req) w_gnt[0] = 1'b1;
               else if (I_uart_req) w_gnt[1] = 1'b1;
            end
            default: begin
               if (I_host_req)      w_gnt[0] = 1'b1;
               else if (I_uart_req) w_gnt[1] = 1'b1;
               else if (w_rd_elig)  w_gnt[2] = 1'b1;
            end
         endcase
      end
      if (!I_Rst_n) w_gnt = 3'b000;
   end

   // Next state: enter lock on a locked read, leave on unlock or count limit
   always_comb begin
      w_state_nxt    = r_state;
      w_lock_cnt_nxt = r_lock_cnt;
      w_excl_rd_nxt  = r_excl_rd;
      case (r_state)
         ST_RR: begin
            w_excl_rd_nxt = 1'b0;
            if (w_gnt[2] && I_rd_lock) begin
               w_state_nxt    = ST_LOCK;
               w_lock_cnt_nxt = C_CNT_W'(1);
            end
         end
         default: begin
            if (w_gnt[2]) begin
               if (r_lock_cnt == C_LOCK_LAST) begin
                  // forced release: give waiting writers the next slot
                  w_state_nxt    = ST_RR;
                  w_lock_cnt_nxt = '0;
                  w_excl_rd_nxt  = 1'b1;
               end else if (!I_rd_lock) begin
                  w_state_nxt    = ST_RR;
                  w_lock_cnt_nxt = '0;
               end else begin
                  w_lock_cnt_nxt = r_lock_cnt + 1'b1;
               end
            end else if (!I_rd_lock) begin
               w_state_nxt    = ST_RR;
               w_lock_cnt_nxt = '0;
            end
         end
      endcase
   end

   // Outputs decoded from grant and state
   always_comb begin
      O_host_ack = w_gnt[0];
      O_uart_ack = w_gnt[1];
      O_rd_ack   = w_gnt[2];
      O_locked   = (r_state == ST_LOCK);
   end

   // State, lock counter, exclusion flag and last-owner registers
   always_ff @(posedge I_clk or negedge I_Rst_n) begin
      if (!I_Rst_n) begin
         r_state    <= ST_RR;
         r_lock_cnt <= '0;
         r_excl_rd  <= 1'b0;
         r_owner    <= C_OWN_NONE;
      end else begin
         r_state    <= w_state_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
         r_excl_rd  <= w_excl_rd_nxt;
         if (w_gnt[0])      r_owner <= C_OWN_HOST;
         else if (w_gnt[1]) r_owner <= C_OWN_UART;
         else if (w_gnt[2]) r_owner <= C_OWN_RD;
      end
   end

   // Registered RAM drive: enable pulses per transfer, other fields hold
   always_ff @(posedge I_clk or negedge I_Rst_n) begin
      if (!I_Rst_n) begin
         r_ram_en    <= 1'b0;
         r_ram_wen   <= '0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
      end else begin
         r_ram_en <= |w_gnt;
         if (w_gnt[0]) begin
            r_ram_wen   <= 16'hFFFF;
            r_ram_addr  <= I_host_addr;
            r_ram_wdata <= I_host_data;
         end else if (w_gnt[1]) begin
            r_ram_wen   <= w_uart_wen;
            r_ram_addr  <= I_uart_addr[ADDR_W+1:2];
            r_ram_wdata <= {4{I_uart_data}};
         end else if (w_gnt[2]) begin
            r_ram_wen   <= 16'h0000;
            r_ram_addr  <= I_rd_addr;
         end
      end
   end

   // Read-valid pipe: one stage for the RAM issue plus RD_LAT of RAM latency
   always_ff @(posedge I_clk or negedge I_Rst_n) begin
      if (!I_Rst_n) r_rd_pipe <= '0;
      else          r_rd_pipe <= {r_rd_pipe[RD_LAT-1:0], w_gnt[2]};
   end

   assign O_ram_en    = r_ram_en;
   assign O_ram_wen   = r_ram_wen;
   assign O_ram_addr  = r_ram_addr;
   assign O_ram_wdata = r_ram_wdata;
   assign O_rd_vld    = r_rd_pipe[RD_LAT];
   assign O_rd_data   = I_ram_rdata;
   assign O_owner     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_port_arbiter
//  Purpose  : Directed self-checking bench for sram_port_arbiter
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

   localparam int AW = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           host_req, uart_req, rd_req, rd_lock;
   logic [AW-1:0]  host_addr, rd_addr;
   logic [127:0]   host_data;
   logic [AW+1:0]  uart_addr;
   logic [31:0]    uart_data;
   logic [127:0]   ram_rdata;

   logic           host_ack, uart_ack, rd_ack, rd_vld, ram_en, locked;
   logic [127:0]   rd_data, ram_wdata;
   logic [15:0]    ram_wen;
   logic [AW-1:0]  ram_addr;
   logic [1:0]     owner;

   logic           host_ack4, uart_ack4, rd_ack4, rd_vld4, ram_en4, locked4;
   logic [127:0]   rd_data4, ram_wdata4;
   logic [15:0]    ram_wen4;
   logic [AW-1:0]  ram_addr4;
   logic [1:0]     owner4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.ADDR_W(AW), .RD_LAT(2), .MAX_LOCK(64)) u_dut (
      .I_clk(clk), .I_Rst_n(rst_n),
      .I_host_req(host_req), .I_host_addr(host_addr), .I_host_data(host_data), .O_host_ack(host_ack),
      .I_uart_req(uart_req), .I_uart_addr(uart_addr), .I_uart_data(uart_data), .O_uart_ack(uart_ack),
      .I_rd_req(rd_req), .I_rd_lock(rd_lock), .I_rd_addr(rd_addr), .O_rd_ack(rd_ack),
      .O_rd_data(rd_data), .O_rd_vld(rd_vld),
      .O_ram_en(ram_en), .O_ram_wen(ram_wen), .O_ram_addr(ram_addr), .O_ram_wdata(ram_wdata),
      .I_ram_rdata(ram_rdata), .O_owner(owner), .O_locked(locked)
   );

   sram_port_arbiter #(.ADDR_W(AW), .RD_LAT(2), .MAX_LOCK(4)) u_dut4 (
      .I_clk(clk), .I_Rst_n(rst_n),
      .I_host_req(host_req), .I_host_addr(host_addr), .I_host_data(host_data), .O_host_ack(host_ack4),
      .I_uart_req(uart_req), .I_uart_addr(uart_addr), .I_uart_data(uart_data), .O_uart_ack(uart_ack4),
      .I_rd_req(rd_req), .I_rd_lock(rd_lock), .I_rd_addr(rd_addr), .O_rd_ack(rd_ack4),
      .O_rd_data(rd_data4), .O_rd_vld(rd_vld4),
      .O_ram_en(ram_en4), .O_ram_wen(ram_wen4), .O_ram_addr(ram_addr4), .O_ram_wdata(ram_wdata4),
      .I_ram_rdata(ram_rdata), .O_owner(owner4), .O_locked(locked4)
   );

   // RAM model with two cycles of read latency, content derived from address
   function automatic logic [127:0] ram_word(input logic [AW-1:0] a);
      return {8{a ^ 16'hA5C3}};
   endfunction

   logic [127:0] ram_p1, ram_p2;
   always @(posedge clk) begin
      ram_p1 <= ram_word(ram_addr);
      ram_p2 <= ram_p1;
   end
   assign ram_rdata = ram_p2;

   task automatic idle(input int n);
      host_req = 1'b0; uart_req = 1'b0; rd_req = 1'b0; rd_lock = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      host_req = 1'b1; uart_req = 1'b1; rd_req = 1'b1; rd_lock = 1'b0;
      host_addr = 16'h0010; host_data = {4{32'hCAFE0001}};
      uart_addr = 18'h00045; uart_data = 32'h12345678; rd_addr = 16'h0033;
      repeat (2) @(negedge clk);
      #1;
      checks++; if ({host_ack, uart_ack, rd_ack} !== 3'b000) begin errors++; $display("FAIL rst_acks: got %b want 000", {host_ack, uart_ack, rd_ack}); end
      checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en: got %b want 0", ram_en); end
      checks++; if (owner !== 2'd3) begin errors++; $display("FAIL rst_owner: got %0d want 3", owner); end
      checks++; if ({rd_vld, locked} !== 2'b00 || ram_wen !== 16'h0) begin errors++; $display("FAIL rst_misc: got vld=%b lock=%b wen=%h want 0", rd_vld, locked, ram_wen); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if ({host_ack, uart_ack, rd_ack} !== 3'b100) begin errors++; $display("FAIL rst_first_ack: got %b want 100", {host_ack, uart_ack, rd_ack}); end
      host_req = 1'b0; uart_req = 1'b0; rd_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_round_robin;
      logic [2:0]  exp_ack [3];
      logic [15:0] exp_wen [3];
      exp_ack[0] = 3'b100; exp_ack[1] = 3'b010; exp_ack[2] = 3'b001;
      exp_wen[0] = 16'hFFFF; exp_wen[1] = 16'h00F0; exp_wen[2] = 16'h0000;
      host_req = 1'b1; uart_req = 1'b1; rd_req = 1'b1; rd_lock = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++; if ({host_ack, uart_ack, rd_ack} !== exp_ack[i%3]) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", i, {host_ack, uart_ack, rd_ack}, exp_ack[i%3]); end
         if (i > 0) begin
            checks++; if (ram_en !== 1'b1 || ram_wen !== exp_wen[(i-1)%3]) begin errors++; $display("FAIL rr_wen[%0d]: got en=%b wen=%h want en=1 wen=%h", i, ram_en, ram_wen, exp_wen[(i-1)%3]); end
            checks++; if (owner !== 2'((i-1)%3)) begin errors++; $display("FAIL rr_owner[%0d]: got %0d want %0d", i, owner, (i-1)%3); end
         end
         if (i == 1) begin
            checks++; if (ram_addr !== 16'h0010 || ram_wdata !== {4{32'hCAFE0001}}) begin errors++; $display("FAIL rr_host_drive: got addr=%h data=%h", ram_addr, ram_wdata); end
         end
         if (i == 5) begin
            checks++; if (rd_vld !== 1'b1 || rd_data !== ram_word(16'h0033)) begin errors++; $display("FAIL rr_rd_data: got vld=%b data=%h want vld=1 data=%h", rd_vld, rd_data, ram_word(16'h0033)); end
         end
         @(negedge clk);
      end
      host_req = 1'b0; uart_req = 1'b0; rd_req = 1'b0;
      #1;
      checks++; if (ram_en !== 1'b1 || ram_wen !== 16'h0000 || ram_addr !== 16'h0033) begin errors++; $display("FAIL rr_last_read: got en=%b wen=%h addr=%h want 1/0000/0033", ram_en, ram_wen, ram_addr); end
      idle(5);
   endtask

   task automatic test_uart_lane;
      uart_addr = 18'h00006; uart_data = 32'hDEADBEEF; uart_req = 1'b1;
      #1;
      checks++; if ({host_ack, uart_ack, rd_ack} !== 3'b010) begin errors++; $display("FAIL uart_ack: got %b want 010", {host_ack, uart_ack, rd_ack}); end
      @(negedge clk);
      uart_req = 1'b0;
      #1;
      checks++; if (ram_en !== 1'b1 || ram_addr !== 16'h0001 || ram_wen !== 16'h0F00) begin errors++; $display("FAIL uart_drive: got en=%b addr=%h wen=%h want 1/0001/0f00", ram_en, ram_addr, ram_wen); end
      checks++; if (ram_wdata !== {4{32'hDEADBEEF}}) begin errors++; $display("FAIL uart_wdata: got %h want %h", ram_wdata, {4{32'hDEADBEEF}}); end
      checks++; if (owner !== 2'd1) begin errors++; $display("FAIL uart_owner: got %0d want 1", owner); end
      @(negedge clk);
      #1;
      checks++; if (ram_en !== 1'b0 || ram_addr !== 16'h0001) begin errors++; $display("FAIL uart_hold: got en=%b addr=%h want 0/0001", ram_en, ram_addr); end
      @(negedge clk);
   endtask

   task automatic test_lock_burst;
      host_addr = 16'h0ABC;
      for (int k = 0; k < 12; k++) begin
         host_req = (k <= 8);
         rd_req   = (k < 8);
         rd_lock  = (k < 7);
         rd_addr  = 16'h0100 + 16'(k);
         #1;
         checks++; if (rd_ack !== (k < 8) || host_ack !== (k == 8) || uart_ack !== 1'b0) begin errors++; $display("FAIL lock_ack[%0d]: got h=%b u=%b r=%b", k, host_ack, uart_ack, rd_ack); end
         checks++; if (rd_vld !== (k >= 3 && k <= 10)) begin errors++; $display("FAIL lock_vld[%0d]: got %b want %b", k, rd_vld, (k >= 3 && k <= 10)); end
         if (k >= 3 && k <= 10) begin
            checks++; if (rd_data !== ram_word(16'h0100 + 16'(k - 3))) begin errors++; $display("FAIL lock_data[%0d]: got %h want %h", k, rd_data, ram_word(16'h0100 + 16'(k - 3))); end
         end
         if (k == 1) begin
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_on: got %b want 1", locked); end
         end
         if (k == 8) begin
            checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_off: got %b want 0", locked); end
         end
         @(negedge clk);
      end
      idle(3);
   endtask

   task automatic test_starvation;
      logic exp_rd [7];
      logic exp_u  [7];
      exp_rd[0] = 1; exp_rd[1] = 1; exp_rd[2] = 1; exp_rd[3] = 1; exp_rd[4] = 0; exp_rd[5] = 1; exp_rd[6] = 1;
      exp_u[0]  = 0; exp_u[1]  = 0; exp_u[2]  = 0; exp_u[3]  = 0; exp_u[4]  = 1; exp_u[5]  = 0; exp_u[6]  = 0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rd_addr = 16'h0040; uart_addr = 18'h00009;
      for (int c = 0; c < 7; c++) begin
         uart_req = (c >= 1); rd_req = 1'b1; rd_lock = 1'b1;
         #1;
         checks++; if (rd_ack4 !== exp_rd[c] || uart_ack4 !== exp_u[c] || host_ack4 !== 1'b0) begin errors++; $display("FAIL starve_ack[%0d]: got r=%b u=%b h=%b want r=%b u=%b", c, rd_ack4, uart_ack4, host_ack4, exp_rd[c], exp_u[c]); end
         if (c == 2 || c == 4) begin
            checks++; if (locked4 !== (c == 2)) begin errors++; $display("FAIL starve_lock[%0d]: got %b want %b", c, locked4, (c == 2)); end
         end
         @(negedge clk);
      end
      idle(5);
   endtask

   task automatic test_reset_midread;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rd_req = 1'b1; rd_lock = 1'b0; rd_addr = 16'h0200;
      #1;
      checks++; if (rd_ack !== 1'b1) begin errors++; $display("FAIL midrst_ack: got %b want 1", rd_ack); end
      @(negedge clk);
      rd_req = 1'b0;
      rst_n = 1'b0;
      for (int j = 0; j < 8; j++) begin
         if (j == 2) rst_n = 1'b1;
         #1;
         checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL midrst_vld[%0d]: got %b want 0", j, rd_vld); end
         @(negedge clk);
      end
      rd_req = 1'b1; rd_addr = 16'h0203;
      #1;
      checks++; if (rd_ack !== 1'b1) begin errors++; $display("FAIL midrst_ack2: got %b want 1", rd_ack); end
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL midrst_early: got %b want 0", rd_vld); end
      @(negedge clk);
      #1;
      checks++; if (rd_vld !== 1'b1 || rd_data !== ram_word(16'h0203)) begin errors++; $display("FAIL midrst_data: got vld=%b data=%h want 1/%h", rd_vld, rd_data, ram_word(16'h0203)); end
      @(negedge clk);
      #1;
      checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL midrst_single: got %b want 0", rd_vld); end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      host_req = 1'b0; uart_req = 1'b0; rd_req = 1'b0; rd_lock = 1'b0;
      host_addr = '0; host_data = '0; uart_addr = '0; uart_data = '0; rd_addr = '0;
      test_reset();
      test_round_robin();
      test_uart_lane();
      test_lock_burst();
      test_starvation();
      test_reset_midread();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
